// File: rtl/cpuy_pkg.sv
// rtl/cpuy_pkg.sv - shared types and constants for the fetch sequencer
package cpuy_pkg;

  localparam int PC_WIDTH         = 8;
  localparam int OPERAND_FLAG_BIT = 7;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_OPCODE,
    ST_FETCH_ARG,
    ST_OPERAND,
    ST_DECODE,
    ST_EXECUTE
  } state_t;

  // Bit 7 of the opcode byte marks a two-byte instruction.
  function automatic logic has_operand(input logic [7:0] op);
    return op[OPERAND_FLAG_BIT];
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - program ROM and decoder signals seen by the fetch sequencer
interface fetch_seq_if;
  import cpuy_pkg::*;

  logic [PC_WIDTH-1:0] prog_addr;
  logic [7:0]          prog_data;
  logic [7:0]          opcode;
  logic [7:0]          operand;
  logic                jump_operation;
  logic                jump_condition;
  logic                stall;
  logic                instr_valid;
  logic [PC_WIDTH-1:0] pc;

  modport master (
    output prog_addr,
    output opcode,
    output operand,
    output instr_valid,
    output pc,
    input  prog_data,
    input  jump_operation,
    input  jump_condition,
    input  stall
  );

  modport slave (
    input  prog_addr,
    input  opcode,
    input  operand,
    input  instr_valid,
    input  pc,
    output prog_data,
    output jump_operation,
    output jump_condition,
    output stall
  );

endinterface

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer: reads one or two ROM bytes, then holds them for EXECUTE
module fetch_seq
  import cpuy_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_RESET = 8'h00
) (
  input  logic      clk,
  input  logic      rst_n,
  fetch_seq_if.master bus
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [7:0]          operand_q, operand_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= PC_RESET;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  // ROM data arrives one cycle after the address, so each byte read is a two-state pair.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_OPCODE;
      end
      ST_OPCODE: begin
        opcode_d = bus.prog_data;
        pc_d     = pc_q + PC_ONE;
        if (has_operand(bus.prog_data)) begin
          state_d = ST_FETCH_ARG;
        end else begin
          operand_d = 8'h00;
          state_d   = ST_DECODE;
        end
      end
      ST_FETCH_ARG: begin
        state_d = ST_OPERAND;
      end
      ST_OPERAND: begin
        operand_d = bus.prog_data;
        pc_d      = pc_q + PC_ONE;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (!bus.stall) begin
          if (bus.jump_operation && bus.jump_condition) begin
            pc_d = operand_q;
          end
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign bus.prog_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_valid = (state_q == ST_EXECUTE);

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - vector table, corner sequences and randomized program run for fetch_seq
module tb_fetch_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_seq_if bus ();

  fetch_seq #(.PC_RESET(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom [256];
  always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string    name;
    logic [7:0] b0, b1;
    bit       jop, jc;
    int       nstall;
    logic [7:0] e_opc, e_opr;
    int       e_lat;
    logic [7:0] e_pcx, e_pcn;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.stall          = 1'($urandom);
    bus.jump_operation = 1'($urandom);
    bus.jump_condition = 1'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rst_pc"},    bus.pc,          8'h00);
    check({tag, ".rst_addr"},  bus.prog_addr,   8'h00);
    check({tag, ".rst_opc"},   bus.opcode,      8'h00);
    check({tag, ".rst_opr"},   bus.operand,     8'h00);
    check({tag, ".rst_valid"}, bus.instr_valid, 1'b0);
  endtask

  // Leaves the DUT in FETCH with the current time counted as cycle 1.
  task automatic reset_dut(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_exec(output int lat, output bit addr_ok);
    lat = 1;
    addr_ok = 1'b1;
    while (!bus.instr_valid && lat < 16) begin
      if (bus.prog_addr !== bus.pc) addr_ok = 1'b0;
      noise();
      step();
      lat++;
    end
    if (bus.prog_addr !== bus.pc) addr_ok = 1'b0;
  endtask

  task automatic exec_instr(input string tag, input logic [7:0] e_opc, input logic [7:0] e_opr,
                            input int e_lat, input logic [7:0] e_pcx, input logic [7:0] e_pcn,
                            input bit jop, input bit jc, input int nstall);
    int lat;
    bit ok;
    wait_exec(lat, ok);
    check({tag, ".lat"},   lat,        e_lat);
    check({tag, ".addr"},  ok,         1'b1);
    check({tag, ".opc"},   bus.opcode,  e_opc);
    check({tag, ".opr"},   bus.operand, e_opr);
    check({tag, ".pcx"},   bus.pc,      e_pcx);
    bus.stall          = 1'b1;
    bus.jump_operation = jop;
    bus.jump_condition = jc;
    for (int i = 0; i < nstall; i++) begin
      step();
      check({tag, ".st_valid"}, bus.instr_valid, 1'b1);
      check({tag, ".st_pc"},    bus.pc,          e_pcx);
      check({tag, ".st_opc"},   bus.opcode,      e_opc);
      check({tag, ".st_opr"},   bus.operand,     e_opr);
    end
    bus.stall = 1'b0;
    step();
    check({tag, ".post_valid"}, bus.instr_valid, 1'b0);
    check({tag, ".pcn"},        bus.pc,          e_pcn);
    check({tag, ".pcn_addr"},   bus.prog_addr,   e_pcn);
    bus.jump_operation = 1'b0;
    bus.jump_condition = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    int lat;
    bit ok;
    logic [7:0] m_pc, a1, b0, b1, pcx, pcn;
    bit two, jop, jc;

    bus.stall = 1'b0;
    bus.jump_operation = 1'b0;
    bus.jump_condition = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    vecs[0] = '{"inc",      8'h02, 8'h00, 0, 0, 0, 8'h02, 8'h00, 4, 8'h01, 8'h01};
    vecs[1] = '{"movlw",    8'h84, 8'h5A, 0, 0, 0, 8'h84, 8'h5A, 6, 8'h02, 8'h02};
    vecs[2] = '{"jmp",      8'hA2, 8'h10, 1, 1, 0, 8'hA2, 8'h10, 6, 8'h02, 8'h10};
    vecs[3] = '{"jmpc_c0",  8'hA4, 8'h20, 1, 0, 0, 8'hA4, 8'h20, 6, 8'h02, 8'h02};
    vecs[4] = '{"jmpc_c1",  8'hA4, 8'h20, 1, 1, 0, 8'hA4, 8'h20, 6, 8'h02, 8'h20};
    vecs[5] = '{"stall3",   8'h84, 8'h5A, 0, 0, 3, 8'h84, 8'h5A, 6, 8'h02, 8'h02};
    vecs[6] = '{"sb_jump",  8'h03, 8'h77, 1, 1, 0, 8'h03, 8'h00, 4, 8'h01, 8'h00};
    vecs[7] = '{"st_jump",  8'hA2, 8'h33, 1, 1, 2, 8'hA2, 8'h33, 6, 8'h02, 8'h33};
    vecs[8] = '{"cond_only",8'hA2, 8'h33, 0, 1, 0, 8'hA2, 8'h33, 6, 8'h02, 8'h02};

    #3;
    for (int v = 0; v < 9; v++) begin
      rom[0] = vecs[v].b0;
      rom[1] = vecs[v].b1;
      reset_dut(vecs[v].name);
      exec_instr(vecs[v].name, vecs[v].e_opc, vecs[v].e_opr, vecs[v].e_lat,
                 vecs[v].e_pcx, vecs[v].e_pcn, vecs[v].jop, vecs[v].jc, vecs[v].nstall);
    end

    // Jump target executes next
    rom[0] = 8'hA2; rom[1] = 8'h10; rom[8'h10] = 8'h00;
    reset_dut("jmp_tgt");
    exec_instr("jmp_tgt.j", 8'hA2, 8'h10, 6, 8'h02, 8'h10, 1, 1, 0);
    exec_instr("jmp_tgt.n", 8'h00, 8'h00, 4, 8'h11, 8'h11, 0, 0, 0);

    // Two-byte instruction at 0xFF with its operand at 0x00, then reset during OPERAND
    rom[0] = 8'hA2; rom[1] = 8'hFF; rom[8'hFF] = 8'h84;
    reset_dut("wrap");
    exec_instr("wrap.j", 8'hA2, 8'hFF, 6, 8'h02, 8'hFF, 1, 1, 0);
    exec_instr("wrap.i", 8'h84, 8'hA2, 6, 8'h01, 8'h01, 0, 0, 0);
    reset_dut("wrap2");
    exec_instr("wrap2.j", 8'hA2, 8'hFF, 6, 8'h02, 8'hFF, 1, 1, 0);
    step();
    step();
    check("wrap2.mid_pc", bus.pc, 8'h00);
    step();
    check("wrap2.opnd_pc", bus.pc, 8'h00);
    check("wrap2.opnd_valid", bus.instr_valid, 1'b0);
    reset_dut("rst_opnd");
    exec_instr("rst_opnd.after", 8'hA2, 8'hFF, 6, 8'h02, 8'h02, 0, 0, 0);

    // Reset while stalled in EXECUTE with a taken jump pending
    rom[0] = 8'hA2; rom[1] = 8'h40;
    reset_dut("rst_stall");
    wait_exec(lat, ok);
    check("rst_stall.lat", lat, 6);
    bus.stall = 1'b1;
    bus.jump_operation = 1'b1;
    bus.jump_condition = 1'b1;
    step();
    step();
    check("rst_stall.held_pc", bus.pc, 8'h02);
    bus.stall = 1'b0;
    reset_dut("rst_stall.r");
    bus.jump_operation = 1'b0;
    bus.jump_condition = 1'b0;
    check("rst_stall.pc_after", bus.pc, 8'h00);
    exec_instr("rst_stall.again", 8'hA2, 8'h40, 6, 8'h02, 8'h02, 0, 0, 0);

    // Random program checked against an instruction-level model
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    reset_dut("rnd");
    m_pc = 8'h00;
    for (int n = 0; n < 150; n++) begin
      b0  = rom[m_pc];
      two = b0[7];
      a1  = m_pc + 8'd1;
      b1  = two ? rom[a1] : 8'h00;
      pcx = m_pc + (two ? 8'd2 : 8'd1);
      jop = 1'($urandom);
      jc  = 1'($urandom);
      pcn = (jop && jc) ? b1 : pcx;
      exec_instr($sformatf("rnd%0d", n), b0, b1, two ? 6 : 4, pcx, pcn, jop, jc,
                 int'($urandom_range(0, 2)));
      m_pc = pcn;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 Port list, one per line: name  direction  width  meaning.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_addr  out  8  program ROM address.
- prog_data  in  8  program ROM read data, valid one cycle after prog_addr.
- opcode  out  8  current instruction byte to the microcode decoder.
- operand  out  8  second instruction byte; 0x00 for single-byte instructions.
- jump_operation  in  1  decoder jump flag.
- jump_condition  in  1  decoder jump-taken flag.
- stall  in  1  hold the current instruction in EXECUTE.
- instr_valid  out  1  high during EXECUTE; opcode, operand and decoder outputs are valid.
- pc  out  8  program counter.
REQ-003 Parameter, one per line: name, default, meaning.
- PC_RESET, 8'h00, pc value after reset.

Function
REQ-004 prog_addr SHALL equal pc combinationally in every state.
REQ-005 The FSM SHALL have the states FETCH, OPCODE, FETCH_ARG, OPERAND, DECODE and EXECUTE.
REQ-006 FETCH SHALL go to OPCODE unconditionally.
REQ-007 OPCODE SHALL perform: opcode <= prog_data; pc <= pc+1; next state FETCH_ARG if prog_data[7]=1, else DECODE with operand <= 0x00.
REQ-008 FETCH_ARG SHALL go to OPERAND unconditionally, with the ROM addressed at the incremented pc.
REQ-009 OPERAND SHALL perform: operand <= prog_data; pc <= pc+1; next state DECODE.
REQ-010 DECODE SHALL last exactly one cycle, giving the registered decoder time to update; next state EXECUTE.
REQ-011 In EXECUTE, instr_valid SHALL be 1; it SHALL be 0 in every other state.
REQ-012 In EXECUTE with stall=1, the block SHALL remain in EXECUTE with pc, opcode and operand unchanged.
REQ-013 In EXECUTE with stall=0: pc <= operand if jump_operation=1 and jump_condition=1, otherwise pc is unchanged; next state FETCH.
REQ-014 A jump with jump_condition=0 SHALL behave as fall-through.
REQ-015 Latency SHALL be 4 cycles per single-byte instruction and 6 cycles per two-byte instruction, from FETCH to the end of EXECUTE, with no stall.
REQ-016 pc arithmetic SHALL be modulo 256: 0xFF+1 = 0x00, including between the opcode and operand bytes.
REQ-017 opcode and operand SHALL be held stable from their capture until the next OPCODE state.
REQ-018 jump_operation and jump_condition SHALL be ignored outside EXECUTE.
REQ-019 stall SHALL be ignored outside EXECUTE.

Reset
REQ-020 Asserting rst_n=0 SHALL immediately force: state FETCH, pc=PC_RESET, opcode=0x00 (NOP), operand=0x00, instr_valid=0.
REQ-021 Reset asserted mid-instruction, including during a stall, SHALL abandon that instruction; no pc update SHALL occur.
REQ-022 After rst_n deasserts, the first rising edge SHALL perform the FETCH->OPCODE transition.

Structure
REQ-023 The shared package cpuy_pkg SHALL hold: the FSM state enum, PC_WIDTH=8, OPERAND_FLAG_BIT=7.
REQ-024 The block SHALL be a single module with no sub-modules; the ROM and the decoder are instantiated by the parent.

Verification
REQ-025 ROM[0]=0x02 (Inc), with the decoder model attached -> opcode=0x02, operand=0x00, instr_valid high on cycle 4, pc=0x01 in EXECUTE.
REQ-026 ROM[0..1]=0x84,0x5A (MovLW) -> operand=0x5A, instr_valid on cycle 6, pc=0x02.
REQ-027 ROM[0..1]=0xA2,0x10 (Jmp), ROM[0x10]=0x00 -> after EXECUTE, prog_addr=0x10 in FETCH and the next opcode is 0x00.
REQ-028 JmpC (0xA4,0x20) with carry=0, then with carry=1 -> pc=0x02 after the first run, 0x20 after the second.
REQ-029 stall held high for 3 cycles in EXECUTE -> instr_valid high for 4 cycles; pc, opcode and operand unchanged; FETCH on the cycle after stall drops.
REQ-030 Two-byte instruction at 0xFF (opcode) with operand at 0x00; separately, rst_n pulsed during OPERAND -> pc wraps to 0x00 then 0x01; after reset, pc=0x00, opcode=0x00, state FETCH.
